// File: rtl/draw_mif_pkg.sv
// draw_mif_pkg: shared FSM states, LT24 command codes, screen size and image table.
// Image dimensions are looked up by id; unknown ids report zero width and height.
package draw_mif_pkg;
    typedef enum logic [3:0] {
        INIT_RST, INIT_WAIT, INIT_CMD, IDLE, SET_COL, SET_PAGE, MEM_WR, PIXELS, DONE
    } state_t;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_MADCTL = 8'h36;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;

    localparam int SCREEN_W = 240;
    localparam int SCREEN_H = 320;

    function automatic logic [7:0] img_w(input logic [7:0] id);
        return id == 8'd0 ? 8'd32 : id == 8'd1 ? 8'd64 : 8'd0;
    endfunction

    function automatic logic [8:0] img_h(input logic [7:0] id);
        return id == 8'd0 ? 9'd32 : id == 8'd1 ? 9'd48 : 9'd0;
    endfunction
endpackage

// File: rtl/draw_mif_rom.sv
// draw_mif_rom: image ROMs with a 1-cycle registered read, row-major addressing.
// Contents are generated test patterns standing in for the MIF images.
module draw_mif_rom
    import draw_mif_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  i_id,
    input  logic [11:0] i_addr,
    output logic [15:0] o_pixel
);
    logic [15:0] r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_q <= 16'h0;
        else r_q <= i_id == 8'd0 ? ({4'h0, i_addr} ^ 16'h5A5A) :
                    i_id == 8'd1 ? {i_addr[5:0], i_addr[11:6], 4'hC} : 16'h0;
    end

    assign o_pixel = r_q;
endmodule

// File: rtl/draw_mif.sv
// draw_mif: LT24 LCD initialiser and ROM image blitter with window setup.
// Every bus word takes two cycles: strobe low, then strobe high with data held.
module draw_mif
    import draw_mif_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] xOrigin,
    input  logic [15:0] yOrigin,
    input  logic [7:0]  mifId,
    input  logic        draw,
    output logic        ready,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Reset_n,
    output logic        LT24LCDOn,
    output logic [15:0] LT24Data,
    output logic [7:0]  imgWidth,
    output logic [8:0]  imgHeight,
    output logic [9:0]  LEDs
);
    localparam int RST_CYC  = CLOCK_FREQ / 1000;
    localparam int WAIT_CYC = CLOCK_FREQ / 1000 * 120;

    state_t      r_state, w_next;
    logic        r_ph, r_rej, r_init;
    logic [2:0]  r_idx;
    logic [31:0] r_cnt;
    logic [11:0] r_pix;
    logic [15:0] r_x, r_y;
    logic [7:0]  r_id, r_w;
    logic [8:0]  r_h;
    logic [7:0]  w_iw;
    logic [8:0]  w_ih;
    logic        w_ok, w_busy, w_rs;
    logic [15:0] w_lo, w_hi, w_pixel, w_data;
    logic [16:0] w_total;
    logic [11:0] w_addr;

    assign w_iw    = img_w(mifId);
    assign w_ih    = img_h(mifId);
    assign w_ok    = (w_iw != 8'd0) && ({1'b0, xOrigin} + 17'(w_iw) <= 17'(SCREEN_W))
                     && ({1'b0, yOrigin} + 17'(w_ih) <= 17'(SCREEN_H));
    assign w_busy  = r_state inside {INIT_CMD, SET_COL, SET_PAGE, MEM_WR, PIXELS};
    assign w_lo    = r_state == SET_COL ? r_x : r_y;
    assign w_hi    = w_lo + (r_state == SET_COL ? {8'b0, r_w} : {7'b0, r_h}) - 16'd1;
    assign w_total = 17'(r_w) * 17'(r_h);
    // Present the next address during the hold cycle so the ROM latency stays hidden.
    assign w_addr  = r_pix + {11'b0, r_state == PIXELS && r_ph};

    draw_mif_rom u_rom (
        .clock   (clock),
        .reset   (reset),
        .i_id    (r_id),
        .i_addr  (w_addr),
        .o_pixel (w_pixel)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= INIT_RST;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT_RST:  w_next = r_cnt == 32'(RST_CYC - 1) ? INIT_WAIT : INIT_RST;
            INIT_WAIT: w_next = r_cnt == 32'(WAIT_CYC - 1) ? INIT_CMD : INIT_WAIT;
            INIT_CMD:  w_next = r_ph && r_idx == 3'd5 ? IDLE : INIT_CMD;
            IDLE:      w_next = draw && w_ok ? SET_COL : IDLE;
            SET_COL:   w_next = r_ph && r_idx == 3'd4 ? SET_PAGE : SET_COL;
            SET_PAGE:  w_next = r_ph && r_idx == 3'd4 ? MEM_WR : SET_PAGE;
            MEM_WR:    w_next = r_ph ? PIXELS : MEM_WR;
            PIXELS:    w_next = r_ph && {5'b0, r_pix} == w_total - 17'd1 ? DONE : PIXELS;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rs   = 1'b0;
        w_data = 16'h0;
        case (r_state)
            INIT_CMD: begin
                w_rs   = r_idx == 3'd2 || r_idx == 3'd4;
                w_data = {8'h0, r_idx == 3'd0 ? CMD_SLPOUT : r_idx == 3'd1 ? CMD_COLMOD :
                                r_idx == 3'd2 ? 8'h55 : r_idx == 3'd3 ? CMD_MADCTL :
                                r_idx == 3'd4 ? 8'h08 : CMD_DISPON};
            end
            SET_COL, SET_PAGE: begin
                w_rs   = r_idx != 3'd0;
                w_data = {8'h0, r_idx == 3'd0 ? (r_state == SET_COL ? CMD_CASET : CMD_PASET) :
                                r_idx == 3'd1 ? w_lo[15:8] : r_idx == 3'd2 ? w_lo[7:0] :
                                r_idx == 3'd3 ? w_hi[15:8] : w_hi[7:0]};
            end
            MEM_WR: w_data = {8'h0, CMD_RAMWR};
            PIXELS: begin
                w_rs   = 1'b1;
                w_data = w_pixel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= 32'd0;
            r_ph   <= 1'b0;
            r_idx  <= 3'd0;
            r_pix  <= 12'd0;
            r_x    <= 16'd0;
            r_y    <= 16'd0;
            r_id   <= 8'd0;
            r_w    <= 8'd0;
            r_h    <= 9'd0;
            r_rej  <= 1'b0;
            r_init <= 1'b0;
        end else begin
            r_cnt <= w_next != r_state ? 32'd0 : r_cnt + 32'd1;
            r_ph  <= w_next == r_state && w_busy && !r_ph;
            r_idx <= w_next != r_state ? 3'd0 : r_idx + {2'b0, r_ph};
            r_pix <= r_state == PIXELS ? r_pix + {11'b0, r_ph} : 12'd0;
            if (r_state == INIT_CMD && w_next == IDLE) r_init <= 1'b1;
            if (r_state == IDLE && draw) begin
                r_rej <= !w_ok;
                if (w_ok) begin
                    r_x  <= xOrigin;
                    r_y  <= yOrigin;
                    r_id <= mifId;
                    r_w  <= w_iw;
                    r_h  <= w_ih;
                end
            end
        end
    end

    assign ready       = r_state == IDLE;
    assign LT24Reset_n = r_state != INIT_RST;
    assign LT24CS_n    = !w_busy;
    assign LT24Wr_n    = !w_busy || r_ph;
    assign LT24Rd_n    = 1'b1;
    assign LT24RS      = w_rs;
    assign LT24Data    = w_data;
    assign LT24LCDOn   = r_init;
    assign imgWidth    = r_w;
    assign imgHeight   = r_h;
    assign LEDs        = {8'b0, r_init, r_rej};
endmodule

// File: tb/tb_draw_mif.sv
// tb_draw_mif: scoreboard bench; a model queues expected LT24 words, a monitor checks the bus.
module tb_draw_mif;
    logic        clock = 1'b0, reset = 1'b0, draw = 1'b0;
    logic [15:0] xOrigin = 16'd0, yOrigin = 16'd0;
    logic [7:0]  mifId = 8'd0;
    logic        ready, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
    logic [15:0] LT24Data;
    logic [7:0]  imgWidth;
    logic [8:0]  imgHeight;
    logic [9:0]  LEDs;

    int          nchk = 0, npass = 0;
    logic [16:0] q[$];
    logic [16:0] last = 17'h0;

    always #5 clock = ~clock;

    draw_mif #(.CLOCK_FREQ(50000)) dut (
        .clock(clock), .reset(reset), .xOrigin(xOrigin), .yOrigin(yOrigin),
        .mifId(mifId), .draw(draw), .ready(ready), .LT24Wr_n(LT24Wr_n),
        .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n), .LT24RS(LT24RS),
        .LT24Reset_n(LT24Reset_n), .LT24LCDOn(LT24LCDOn), .LT24Data(LT24Data),
        .imgWidth(imgWidth), .imgHeight(imgHeight), .LEDs(LEDs)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic int mw(input int id);
        return id == 0 ? 32 : id == 1 ? 64 : 0;
    endfunction

    function automatic int mh(input int id);
        return id == 0 ? 32 : id == 1 ? 48 : 0;
    endfunction

    function automatic logic [15:0] mpix(input int id, input int a);
        logic [11:0] b;
        b = a[11:0];
        return id == 0 ? ({4'h0, b} ^ 16'h5A5A) : {b[5:0], b[11:6], 4'hC};
    endfunction

    function automatic bit acc(input int x, input int y, input int id);
        return id < 2 && x + mw(id) <= 240 && y + mh(id) <= 320;
    endfunction

    task automatic push(input logic rs, input int v);
        q.push_back({rs, v[15:0]});
    endtask

    task automatic push_init();
        push(0, 'h11); push(0, 'h3A); push(1, 'h55);
        push(0, 'h36); push(1, 'h08); push(0, 'h29);
    endtask

    task automatic push_draw(input int x, input int y, input int id);
        int w, h;
        w = mw(id);
        h = mh(id);
        push(0, 'h2A); push(1, x >> 8); push(1, x & 255);
        push(1, (x + w - 1) >> 8); push(1, (x + w - 1) & 255);
        push(0, 'h2B); push(1, y >> 8); push(1, y & 255);
        push(1, (y + h - 1) >> 8); push(1, (y + h - 1) & 255);
        push(0, 'h2C);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) push(1, int'(mpix(id, r * w + c)));
    endtask

    always @(negedge clock) begin
        if (reset && !LT24CS_n) begin
            if (!LT24Wr_n) begin
                if (q.size() == 0) begin
                    nchk++;
                    $display("FAIL unexpected_write: got %0h want none", {LT24RS, LT24Data});
                end else begin
                    last = q.pop_front();
                    chk("bus_word", {15'b0, LT24RS, LT24Data}, {15'b0, last});
                end
            end else chk("bus_hold", {15'b0, LT24RS, LT24Data}, {15'b0, last});
        end
    end

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (!(ready && q.size() == 0) && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk("ready_timeout", {31'b0, ready && q.size() == 0}, 32'd1);
    endtask

    task automatic do_draw(input int x, input int y, input int id);
        bit a;
        int n;
        a = acc(x, y, id);
        @(negedge clock);
        xOrigin = x[15:0];
        yOrigin = y[15:0];
        mifId = id[7:0];
        draw = 1'b1;
        if (a) push_draw(x, y, id);
        @(posedge clock);
        #1 draw = 1'b0;
        chk("ready_after_draw", {31'b0, ready}, {31'b0, !a});
        chk("led_reject", {31'b0, LEDs[0]}, {31'b0, !a});
        if (a) begin
            wait_ready(8000, n);
            chk("img_width", {24'b0, imgWidth}, 32'(mw(id)));
            chk("img_height", {23'b0, imgHeight}, 32'(mh(id)));
        end else repeat (5) @(negedge clock);
        chk("ready_idle", {31'b0, ready}, 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_lcd_reset", {31'b0, LT24Reset_n}, 32'd0);
        chk("rst_cs", {31'b0, LT24CS_n}, 32'd1);
        chk("rst_wr", {31'b0, LT24Wr_n}, 32'd1);
        chk("rst_rd", {31'b0, LT24Rd_n}, 32'd1);
        chk("rst_rs", {31'b0, LT24RS}, 32'd0);
        chk("rst_data", {16'b0, LT24Data}, 32'd0);
        chk("rst_lcdon", {31'b0, LT24LCDOn}, 32'd0);
        chk("rst_width", {24'b0, imgWidth}, 32'd0);
        chk("rst_height", {23'b0, imgHeight}, 32'd0);
        chk("rst_leds", {22'b0, LEDs}, 32'd0);
    endtask

    task automatic release_and_init();
        int n;
        push_init();
        @(negedge clock);
        reset = 1'b1;
        wait_ready(7000, n);
        chk("init_cycles_min", {31'b0, n >= 6062}, 32'd1);
        chk("init_cycles_max", {31'b0, n <= 6064}, 32'd1);
        chk("lcd_on", {31'b0, LT24LCDOn}, 32'd1);
        chk("leds_init", {22'b0, LEDs}, 32'd2);
    endtask

    initial begin
        int n;
        repeat (5) @(posedge clock);
        #1 check_reset_outputs();
        release_and_init();

        do_draw(10, 10, 0);
        do_draw(220, 10, 0);
        do_draw(10, 10, 5);
        do_draw(208, 288, 0);
        do_draw(209, 0, 0);
        do_draw(0, 273, 1);
        do_draw(176, 272, 1);
        for (int i = 0; i < 3; i++)
            do_draw(int'($urandom_range(0, 250)), int'($urandom_range(0, 330)),
                    int'($urandom_range(0, 2)));

        push_draw(20, 30, 1);
        push_draw(20, 30, 1);
        @(negedge clock);
        xOrigin = 16'd20;
        yOrigin = 16'd30;
        mifId = 8'd1;
        draw = 1'b1;
        n = 0;
        while (ready && n < 10) begin @(negedge clock); n++; end
        chk("held_start", {31'b0, ready}, 32'd0);
        n = 0;
        while (!ready && n < 8000) begin @(negedge clock); n++; end
        chk("held_first_done", {31'b0, ready}, 32'd1);
        chk("held_first_words", 32'(q.size()), 32'(11 + 3072));
        @(posedge clock);
        #1 draw = 1'b0;
        chk("held_second_start", {31'b0, ready}, 32'd0);
        wait_ready(8000, n);
        chk("held_led", {31'b0, LEDs[0]}, 32'd0);

        push_draw(0, 0, 1);
        @(negedge clock);
        xOrigin = 16'd0;
        yOrigin = 16'd0;
        draw = 1'b1;
        @(posedge clock);
        #1 draw = 1'b0;
        n = 0;
        while (q.size() > 2000 && n < 8000) begin @(negedge clock); n++; end
        chk("mid_pixels_reached", {31'b0, q.size() <= 2000}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_lcd_reset", {31'b0, LT24Reset_n}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        chk("abort_cs", {31'b0, LT24CS_n}, 32'd1);
        repeat (3) @(negedge clock);
        #1 check_reset_outputs();
        q.delete();
        release_and_init();
        do_draw(5, 6, 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/draw_mif.md
DRAW_MIF -- requirements
Module: draw_mif

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, giving the clock frequency in Hz; used for LCD delay timing.
REQ-002 SHALL have clock: input, 1 bit, system clock; all logic is on the rising edge; one clock domain only.
REQ-003 SHALL have reset: input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have xOrigin: input, 16 bits, image top-left column in pixels.
REQ-005 SHALL have yOrigin: input, 16 bits, image top-left row in pixels.
REQ-006 SHALL have mifId: input, 8 bits, image selector.
REQ-007 SHALL have draw: input, 1 bit, draw request, level-sensitive.
REQ-008 SHALL have ready: output, 1 bit, high when idle and able to accept draw.
REQ-009 SHALL have the LT24 bus outputs LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn: 1 bit each, standard LT24 control signals.
REQ-010 SHALL have LT24Data: output, 16 bits, LT24 command/parameter/pixel bus.
REQ-011 SHALL have imgWidth: output, 8 bits, width of the latched image.
REQ-012 SHALL have imgHeight: output, 9 bits, height of the latched image.
REQ-013 SHALL have LEDs: output, 10 bits, status: bit0 = last draw rejected, bit1 = init done, others 0.

Function
REQ-014 States: INIT_RST, INIT_WAIT, INIT_CMD, IDLE, SET_COL, SET_PAGE, MEM_WR, PIXELS, DONE.
REQ-015 INIT_RST holds LT24Reset_n low for 1 ms (CLOCK_FREQ/1000 cycles), then releases it.
REQ-016 INIT_WAIT lasts 120 ms.
REQ-017 INIT_CMD writes, in order: 0x11 (sleep out), 0x3A with parameter 0x55 (RGB565), 0x36 with parameter 0x08, then 0x29 (display on).
REQ-018 After INIT_CMD, LT24LCDOn = 1, LEDs[1] = 1, then go to IDLE.
REQ-019 Bus write = 2 cycles: cycle 1 LT24CS_n = 0, LT24Wr_n = 0, LT24RS/LT24Data valid; cycle 2 LT24Wr_n = 1 with data/RS held. LT24RS = 0 for commands, 1 for parameters and pixels.
REQ-020 LT24Rd_n SHALL be constantly 1. LT24CS_n = 1 whenever no write is in progress.
REQ-021 ready = 1 only in IDLE.
REQ-022 draw is sampled only in IDLE. On acceptance, xOrigin, yOrigin, mifId and the looked-up dimensions are latched, and ready = 0 on the next cycle.
REQ-023 Image table: mifId 0 = 32x32 RGB565 ROM; mifId 1 = 64x48 ROM. Both ROMs are MIF-initialised, row-major, address = row*width + col.
REQ-024 Rejection: an unknown mifId, xOrigin+width > 240, or yOrigin+height > 320 is rejected. On rejection: no bus writes, LEDs[0] = 1, remain in IDLE with ready high. A valid accept clears LEDs[0].
REQ-025 Window setup (range limits; pixel streaming is REQ-026):
- SET_COL: command 0x2A, then params xs[15:8], xs[7:0], xe[15:8], xe[7:0], where xs = xOrigin and xe = xOrigin+width-1.
- SET_PAGE: command 0x2B, then the same four-parameter format for yOrigin..yOrigin+height-1.
- MEM_WR: command 0x2C.
REQ-026 PIXELS streams exactly width*height words in ROM order, with ROM latency of 1 cycle hidden behind the 2-cycle write.
REQ-027 DONE lasts 1 cycle, then IDLE with ready = 1.
REQ-028 A draw held high during a draw is ignored. If still high when IDLE is re-entered, it starts a new draw.
REQ-029 Address arithmetic SHALL be 17 bits wide to avoid wrap; the pixel counter is 12 bits.

Reset
REQ-030 On reset low, SHALL go to INIT_RST with: ready = 0, LT24Reset_n = 0, LT24CS_n = 1, LT24Wr_n = 1, LT24Rd_n = 1, LT24RS = 0, LT24Data = 0, LT24LCDOn = 0, imgWidth = 0, imgHeight = 0, LEDs = 0.
REQ-031 Reset mid-draw SHALL abort immediately and restart the full LCD init sequence.

Structure
REQ-032 Shared package draw_mif_pkg SHALL hold: the state enum, LT24 command constants (0x11, 0x29, 0x2A, 0x2B, 0x2C, 0x36, 0x3A), screen size 240x320, and the image dimension table.
REQ-033 One sub-module, draw_mif_rom, SHALL map mifId plus pixel address to a 16-bit pixel with 1-cycle registered read.

Verification
REQ-034 Assert reset low for 5 cycles -> all outputs at reset values; ready rises only after the 1 ms + 120 ms + init command writes; LT24LCDOn = 1.
REQ-035 xOrigin = 10, yOrigin = 10, mifId = 0, draw = 1 -> ready falls next cycle; bus shows 0x2A params 00,0A,00,29; then 0x2B params 00,0A,00,29; then 0x2C; then 1024 pixel writes matching the ROM in order; ready returns high; imgWidth = 32, imgHeight = 32.
REQ-036 xOrigin = 220, mifId = 0 -> no LT24CS_n activity, ready stays 1, LEDs[0] = 1.
REQ-037 mifId = 5 -> rejected as in REQ-036.
REQ-038 draw held high throughout a mifId 1 draw -> 3072 pixels, then an immediate second draw; no pixels dropped.
REQ-039 Reset pulsed during PIXELS -> LT24Reset_n = 0 and ready = 0 immediately; init repeats.
